data_mem_hs: RTL and testbench
==============================

Name: data_mem_hs

Overview:
Parametrised, handshaked data memory. It is the next generation of the CPU data memory.
- Single-outstanding request/response interface with a programmable wait-state counter.
- Byte-lane write enables; byte addressing converted to word index.
- Alignment and range errors are reported on the response instead of being silently aliased.
- Sits between the datapath/controller and storage, so multicycle and pipelined cores can stall on memory latency.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 32, byte-address width.
DEPTH, 32, number of words stored.
WAIT_CYCLES, 1, extra cycles between acceptance and response; 0 is legal.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte-lane write enables; ignored for reads
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  misaligned or out-of-range access

Behaviour:
- Word index = req_addr >> log2(DATA_W/8).
- Error conditions:
  - any low byte-offset bit nonzero → misaligned;
  - word index >= DEPTH → out of range.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid, capture we/addr/wdata/be and the error flag.
  - Go to WAIT and load counter=WAIT_CYCLES-1, or go to RESP directly if WAIT_CYCLES==0.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - Counter decrements each cycle; move to RESP on the edge where it reaches 0.
- Commit edge (the edge entering RESP):
  - Write without error: each lane with be[i]=1 updates byte i of the word; other lanes are unchanged.
  - Read without error: the word is registered into rsp_rdata.
  - Error: memory untouched, rsp_rdata=0, rsp_err=1.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the acceptance edge.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On rsp_ready=1, go to IDLE; no new request is accepted in that same cycle.
- Simultaneous events: req_valid during WAIT or RESP is ignored, and the requester must hold it. A write with be=0 completes without error and changes nothing.
- Reset:
  - state=IDLE, counter=0, req_ready=1 in the cycle after reset, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Reset during WAIT aborts the request; an uncommitted write is discarded.
  - Memory contents are never cleared by rst.
- Storage is a register array with a single write port, inferable as distributed/block RAM.

Optional Feature:
DATA_MEM_PRELOAD_EN
- Defined: an initial block loads word i = 10*(i+1) for i=0..9 (sum 550); remaining words are 0.
- Undefined: no initial contents; simulation words start as X until written.

Decomposition:
- Shared package data_mem_pkg holds:
  - the state enum typedef (IDLE/WAIT/RESP);
  - localparam helpers for BE_W=DATA_W/8, OFS_W=log2(BE_W) and IDX_W=log2(DEPTH);
  - the preload constants (PRELOAD_N=10, PRELOAD_STEP=10).
- One natural sub-module: data_mem_array, the storage array with byte-enable write and registered read.
- data_mem_hs itself holds the FSM, counter and error checks.

Test Plan:
- Preload on, WAIT_CYCLES=1: read addresses 0x00..0x24 and accumulate → rdata 10..100, sum 550, each rsp_valid 2 cycles after acceptance.
- Write 0xDEADBEEF to 0x08 with be=4'b0101, then read 0x08 (preload 30) → 0x00AD00EF.
- Read 0x06 → rsp_err=1, rdata=0. Write 0x80 (index 32, DEPTH=32) → rsp_err=1, memory unchanged.
- Hold rsp_ready=0 for 5 cycles → rsp_valid/rdata stable, req_ready=0 throughout; after the ready cycle, IDLE, and the next request is accepted one cycle later.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds → response 1 and 4 cycles after acceptance, respectively.
- Assert rst during WAIT of a write 0x12345678 to 0x04 → outputs at reset values next cycle; a later read of 0x04 returns the prior value (20).

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the handshaked data memory: FSM state encoding,
// width helpers and the preload constants used when DATA_MEM_PRELOAD_EN is defined.
package data_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Widths for the default 32-bit, 32-word configuration
    localparam int BE_W  = 32 / 8;
    localparam int OFS_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(32);

    // Preload pattern: word i holds PRELOAD_STEP*(i+1) for i < PRELOAD_N
    localparam int PRELOAD_N    = 10;
    localparam int PRELOAD_STEP = 10;

    // Number of byte lanes in a data word
    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

    // Number of byte-offset bits below the word index
    function automatic int ofs_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Word index width, never narrower than one bit
    function automatic int idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Wait counter width; the counter only holds 0..wait_cycles-1
    function automatic int cnt_w(input int wait_cycles);
        return (wait_cycles <= 2) ? 1 : $clog2(wait_cycles);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with per-byte write enables and a registered read port.
// With DATA_MEM_PRELOAD_EN defined the array starts with the preload pattern,
// otherwise its contents are undefined until written. rst only clears the read register.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic                        clr,
    input  logic [idx_w(DEPTH)-1:0]     idx,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [be_w(DATA_W)-1:0]     be,
    output logic [DATA_W-1:0]           rdata
);

    localparam int LANES = be_w(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

`ifdef DATA_MEM_PRELOAD_EN
    // Load the known pattern so software can read meaningful data without a prior write
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = (i < PRELOAD_N) ? DATA_W'(PRELOAD_STEP * (i + 1)) : '0;
        end
    end
`endif

    // Single write port: only lanes with their byte enable set are updated
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read data is captured on a read commit and forced to zero for writes and errors
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem[idx];
        end else if (clr) begin
            rdata_d = '0;
        end
    end

    // Registered read port, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_hs.sv
// Handshaked data memory: single outstanding request, WAIT_CYCLES extra wait
// states, byte-lane writes and error reporting for misaligned / out-of-range
// accesses. Optional preload of the storage is selected with DATA_MEM_PRELOAD_EN.
module data_mem_hs
    import data_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [be_w(DATA_W)-1:0]   req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err
);

    localparam int LANES    = be_w(DATA_W);
    localparam int OFS_BITS = ofs_w(DATA_W);
    localparam int IDX_BITS = idx_w(DEPTH);
    localparam int CNT_W    = cnt_w(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]    be_q, be_d;
    logic                err_q, err_d;
    logic                rsp_err_q, rsp_err_d;
    logic                commit;

    logic [ADDR_W-1:0]   word_addr;
    logic [IDX_BITS-1:0] req_idx;
    logic                req_err;

    logic                c_we;
    logic [IDX_BITS-1:0] c_idx;
    logic [DATA_W-1:0]   c_wdata;
    logic [LANES-1:0]    c_be;
    logic                c_err;

    // Decode the incoming byte address into a word index and an error flag
    always_comb begin
        word_addr = req_addr >> OFS_BITS;
        req_idx   = word_addr[IDX_BITS-1:0];
        req_err   = ((req_addr & ADDR_W'(LANES - 1)) != '0) ||
                    (word_addr >= ADDR_W'(DEPTH));
    end

    // With zero wait states the commit happens on the acceptance edge, so use the live request
    always_comb begin
        if (state_q == ST_IDLE) begin
            c_we    = req_we;
            c_idx   = req_idx;
            c_wdata = req_wdata;
            c_be    = req_be;
            c_err   = req_err;
        end else begin
            c_we    = we_q;
            c_idx   = idx_q;
            c_wdata = wdata_q;
            c_be    = be_q;
            c_err   = err_q;
        end
    end

    // Request FSM: accept in IDLE, count down wait states, hold the response until taken
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = err_q;
        rsp_err_d = rsp_err_q;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = req_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (commit) begin
            rsp_err_d = c_err;
        end
    end

    // State registers; reset aborts any request in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            err_q     <= err_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Storage commits are suppressed on errors and whenever reset is asserted
    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .wr_en (commit && c_we && !c_err && !rst),
        .rd_en (commit && !c_we && !c_err && !rst),
        .clr   (commit && (c_we || c_err)),
        .idx   (c_idx),
        .wdata (c_wdata),
        .be    (c_be),
        .rdata (rsp_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: main instance with WAIT_CYCLES=1 plus
// WAIT_CYCLES=0 and WAIT_CYCLES=3 instances for latency. Without
// DATA_MEM_PRELOAD_EN the bench writes the preload pattern itself first.
module tb_data_mem_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        req_valid_x = 1'b0;
    logic        rsp_ready_x = 1'b1;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic        req_ready3, rsp_valid3, rsp_err3;
    logic [31:0] rsp_rdata0, rsp_rdata3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_x), .req_ready(req_ready0), .req_we(1'b0),
        .req_addr(32'h0), .req_wdata(32'h0), .req_be(4'h0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready_x),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    data_mem_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_x), .req_ready(req_ready3), .req_we(1'b0),
        .req_addr(32'h0), .req_wdata(32'h0), .req_be(4'h0),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready_x),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    // Issue one request with rsp_ready held high; report data, error and latency
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata,
                          output logic err, output int lat);
        int t;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1; rsp_ready = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata;
        err = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        checks++;
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_sum();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          sum;
`ifndef DATA_MEM_PRELOAD_EN
        for (int i = 0; i < 10; i++) begin
            do_req(1'b1, 32'(i * 4), 32'(10 * (i + 1)), 4'hF, rd, er, lat);
        end
`endif
        sum = 0;
        for (int i = 0; i < 10; i++) begin
            do_req(1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er, lat);
            sum += int'(rd);
            if (rd !== 32'(10 * (i + 1))) begin errors++; $display("FAIL read_word%0d got=%0d exp=%0d", i, rd, 10 * (i + 1)); end
            checks++;
            if (er !== 1'b0) begin errors++; $display("FAIL read_err%0d got=%b exp=0", i, er); end
            checks++;
            if (lat != 2) begin errors++; $display("FAIL read_latency%0d got=%0d exp=2", i, lat); end
            checks++;
        end
        if (sum != 550) begin errors++; $display("FAIL read_sum got=%0d exp=550", sum); end
        checks++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h08, 32'hDEADBEEF, 4'b0101, rd, er, lat);
        if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL be_write_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
        checks++;
        do_req(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
        if (rd !== 32'h00AD00EF) begin errors++; $display("FAIL be_readback got=%h exp=00ad00ef", rd); end
        checks++;
        do_req(1'b1, 32'h0C, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        if (er !== 1'b0) begin errors++; $display("FAIL be_zero_err got=%b exp=0", er); end
        checks++;
        do_req(1'b0, 32'h0C, 32'h0, 4'h0, rd, er, lat);
        if (rd !== 32'd40) begin errors++; $display("FAIL be_zero_unchanged got=%0d exp=40", rd); end
        checks++;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b0, 32'h06, 32'h0, 4'h0, rd, er, lat);
        if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_read got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        checks++;
        do_req(1'b1, 32'h80, 32'hCAFEF00D, 4'hF, rd, er, lat);
        if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL range_write got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        checks++;
        do_req(1'b0, 32'h00, 32'h0, 4'h0, rd, er, lat);
        if (rd !== 32'd10) begin errors++; $display("FAIL range_no_alias got=%0d exp=10", rd); end
        checks++;
        do_req(1'b1, 32'h7C, 32'h11223344, 4'hF, rd, er, lat);
        do_req(1'b0, 32'h7C, 32'h0, 4'h0, rd, er, lat);
        if (er !== 1'b0 || rd !== 32'h11223344) begin errors++; $display("FAIL last_word got err=%b rdata=%h exp err=0 rdata=11223344", er, rd); end
        checks++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_addr = 32'h14;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd50 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got valid=%b rdata=%0d ready=%b exp valid=1 rdata=50 ready=0",
                         k, rsp_valid, rsp_rdata, req_ready);
            end
            checks++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL after_take got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready); end
        checks++;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL next_accept got ready=%b exp=0", req_ready); end
        checks++;
        @(posedge clk);
        #1;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd60) begin errors++; $display("FAIL next_resp got valid=%b rdata=%0d exp valid=1 rdata=60", rsp_valid, rsp_rdata); end
        checks++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_during_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h04; req_wdata = 32'h12345678; req_be = 4'hF;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL wait_reset_outputs got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat);
        if (rd !== 32'd20) begin errors++; $display("FAIL wait_reset_discard got=%h exp=14", rd); end
        checks++;
    endtask

    task automatic test_latency();
        int first0;
        int first3;
        first0 = 0;
        first3 = 0;
        @(negedge clk);
        req_valid_x = 1'b1; rsp_ready_x = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) req_valid_x = 1'b0;
            if (rsp_valid0 && first0 == 0) first0 = k;
            if (rsp_valid3 && first3 == 0) first3 = k;
        end
        if (first0 != 1) begin errors++; $display("FAIL latency_wait0 got=%0d exp=1", first0); end
        checks++;
        if (first3 != 4) begin errors++; $display("FAIL latency_wait3 got=%0d exp=4", first3); end
        checks++;
        if (req_ready0 !== 1'b1 || req_ready3 !== 1'b1 || rsp_err0 !== 1'b0 || rsp_err3 !== 1'b0) begin
            errors++;
            $display("FAIL latency_idle got ready0=%b ready3=%b err0=%b err3=%b exp 1 1 0 0",
                     req_ready0, req_ready3, rsp_err0, rsp_err3);
        end
        checks++;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_latency();
        test_read_sum();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_reset_during_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
